interrupt_control: RTL and testbench
====================================

Name: interrupt_control

Overview:
- Interrupt and reset sequencer for the cpu6502 core. Sits directly upstream of the processor status register.
- Synchronises the external NMI and IRQ pins, latches NMI edges, and samples IRQ against the I flag from the status register at instruction boundaries.
- Arbitrates reset, NMI, IRQ and BRK, and supplies the vector address.
- Drives the B value to push and the set-I pulse consumed by the status register.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for i_nmi_n and i_irq_n (>=2).
- NMI_VECTOR, 16'hFFFA, NMI vector address.
- RESET_VECTOR, 16'hFFFC, reset vector address.
- IRQ_VECTOR, 16'hFFFE, IRQ and BRK vector address.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_reset_n  input  1  synchronous active-low reset.
- i_nmi_n  input  1  external NMI pin, asynchronous, active low, edge-sensitive.
- i_irq_n  input  1  external IRQ pin, asynchronous, active low, level-sensitive.
- i_p_i  input  1  I flag from the processor status register.
- i_sync  input  1  one-cycle strobe on the last cycle of each instruction (poll point).
- i_brk  input  1  current opcode is BRK; qualifies i_ack.
- i_ack  input  1  core starts an interrupt/BRK sequence this cycle.
- i_vec_rd  input  1  core fetches the vector low byte this cycle (commit point).
- o_int_pending  output  1  a reset or hardware interrupt is waiting for i_ack.
- o_in_service  output  1  a sequence is between ack and vector commit.
- o_kind  output  2  0=RESET, 1=NMI, 2=IRQ, 3=BRK.
- o_vector  output  16  vector address for the current or pending sequence.
- o_b_flag  output  1  B bit to push: 1 only for BRK.
- o_set_i  output  1  one-cycle pulse telling the status register to set I.
- o_nmi_latched  output  1  NMI edge latch, for debug and verification.

Behaviour:
- Reset: one clock, synchronous active-low reset on i_reset_n sampled at i_clk rising edge.
  - While i_reset_n=0: state=S_RESET, synchronisers and edge history=1, NMI latch=0, o_int_pending=1, o_in_service=0, o_kind=0, o_vector=RESET_VECTOR, o_b_flag=0, o_set_i=0, o_nmi_latched=0.
  - Reset asserted in any state, including mid-sequence, aborts that sequence and returns to these values on the next edge.
- Synchroniser: SYNC_STAGES flops per pin.
  - NMI edge = synced NMI is 0 and the previous synced value was 1.
  - o_nmi_latched rises on the (SYNC_STAGES+1)th edge that samples i_nmi_n low.
  - Pulses shorter than one clock are not guaranteed to be captured.
- NMI latch:
  - Set by an edge, cleared when an NMI vector is committed.
  - An edge in the same cycle as the clear leaves the latch at 1.
  - Holding i_nmi_n low produces exactly one edge.
- irq_active = synced IRQ is 0 and i_p_i=0.
- Encoded as registers; outputs are registered or decoded from state only.
- S_RESET: o_int_pending=1. i_ack -> S_SERVICE with kind RESET and o_vector=RESET_VECTOR; i_brk is ignored.
- S_IDLE:
  - i_sync with latch=1 -> S_PENDING, kind NMI, NMI_VECTOR.
  - Else i_sync with irq_active -> S_PENDING, kind IRQ, IRQ_VECTOR.
  - Else i_ack with i_brk=1 -> S_SERVICE, kind BRK, IRQ_VECTOR, o_b_flag=1.
  - i_ack without i_brk is ignored.
- S_PENDING:
  - Decision is committed: IRQ deasserting or I becoming 1 does not cancel it.
  - i_ack -> S_SERVICE; o_b_flag=0.
- S_SERVICE:
  - i_ack and i_sync are ignored.
  - On i_vec_rd -> S_IDLE next edge and o_set_i=1 for exactly that next cycle.
  - Hijack: if kind is IRQ or BRK and latch=1 at i_vec_rd, o_kind becomes NMI, o_vector becomes NMI_VECTOR, and the latch clears. o_b_flag keeps its BRK value.
  - If kind is NMI, the latch clears at i_vec_rd.
  - RESET kind never hijacks.
- o_vector and o_kind are stable from the ack edge until the next sequence, except the hijack update on the i_vec_rd edge. Consumers read the value after that edge.
- Priority at the poll point: RESET > NMI > IRQ. BRK is taken only when nothing is pending at ack.
- o_in_service = (state==S_SERVICE). o_int_pending = (state==S_RESET or S_PENDING).

Test Plan:
- Reset low 3 cycles, release -> o_int_pending=1, o_vector=16'hFFFC, o_kind=0. i_ack then i_vec_rd -> o_set_i pulses 1 cycle, state IDLE, o_int_pending=0.
- i_nmi_n low at edge 0 (held) -> o_nmi_latched=1 after edge 2. i_sync -> o_kind=1, o_vector=16'hFFFA. ack + vec_rd -> latch=0. No second NMI while pin stays low.
- i_irq_n=0, i_p_i=1, i_sync -> no pending. i_p_i=0, i_sync -> o_kind=2, o_vector=16'hFFFE. i_irq_n released before i_ack -> still serviced, o_b_flag=0.
- BRK: i_ack+i_brk in IDLE -> o_kind=3, o_b_flag=1. NMI edge latched before i_vec_rd -> after vec_rd o_vector=16'hFFFA, o_kind=1, o_b_flag=1, latch cleared.
- NMI edge on the same cycle as the NMI i_vec_rd clear -> o_nmi_latched stays 1. The next i_sync raises an NMI pending.
- Reset asserted during S_SERVICE of an IRQ -> no o_set_i pulse. After release, o_vector=16'hFFFC and o_nmi_latched=0.

Source files
------------

// File: rtl/interrupt_control_if.sv
// Signal bundle between the cpu6502 core and the interrupt/reset sequencer.
// Clock and reset are plain ports on the sequencer, so they are not part of this bundle.
interface interrupt_control_if;
  logic        i_nmi_n;
  logic        i_irq_n;
  logic        i_p_i;
  logic        i_sync;
  logic        i_brk;
  logic        i_ack;
  logic        i_vec_rd;
  logic        o_int_pending;
  logic        o_in_service;
  logic [1:0]  o_kind;
  logic [15:0] o_vector;
  logic        o_b_flag;
  logic        o_set_i;
  logic        o_nmi_latched;

  // Core side: drives the pins and strobes, and reads back the sequencer outputs.
  modport master (
    output i_nmi_n, i_irq_n, i_p_i, i_sync, i_brk, i_ack, i_vec_rd,
    input  o_int_pending, o_in_service, o_kind, o_vector, o_b_flag, o_set_i, o_nmi_latched
  );

  // Sequencer side.
  modport slave (
    input  i_nmi_n, i_irq_n, i_p_i, i_sync, i_brk, i_ack, i_vec_rd,
    output o_int_pending, o_in_service, o_kind, o_vector, o_b_flag, o_set_i, o_nmi_latched
  );
endinterface

// File: rtl/interrupt_control.sv
// Interrupt and reset sequencer for the cpu6502 core.
// Synchronises NMI/IRQ, latches NMI edges, arbitrates RESET/NMI/IRQ/BRK and
// supplies the vector, the B value to push and the set-I pulse.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_RESET   | reset seen, waiting for the core to start the reset sequence
// S_IDLE    | nothing pending; polling at i_sync, BRK accepted at i_ack
// S_PENDING | NMI or IRQ decided at a poll point, waiting for i_ack
// S_SERVICE | sequence running, waiting for the vector low-byte fetch
module interrupt_control #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE
) (
  input logic               i_clk,
  input logic               i_reset_n,
  interrupt_control_if.slave bus
);

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_IDLE    = 2'd1,
    S_PENDING = 2'd2,
    S_SERVICE = 2'd3
  } state_t;

  localparam logic [1:0] KIND_RESET = 2'd0;
  localparam logic [1:0] KIND_NMI   = 2'd1;
  localparam logic [1:0] KIND_IRQ   = 2'd2;
  localparam logic [1:0] KIND_BRK   = 2'd3;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] nmi_sync_q;
  logic [SYNC_STAGES-1:0] irq_sync_q;
  logic                   nmi_prev_q;
  logic                   nmi_latch_q, nmi_latch_d;
  logic [1:0]             kind_q, kind_d;
  logic [15:0]            vector_q, vector_d;
  logic                   b_flag_q, b_flag_d;
  logic                   set_i_q, set_i_d;

  logic nmi_edge;
  logic irq_active;
  logic nmi_clear;

  assign nmi_edge   = ~nmi_sync_q[SYNC_STAGES-1] & nmi_prev_q;
  assign irq_active = ~irq_sync_q[SYNC_STAGES-1] & ~bus.i_p_i;

  // Pin synchronisers and NMI edge history; idle level is high.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      nmi_sync_q <= '1;
      irq_sync_q <= '1;
      nmi_prev_q <= 1'b1;
    end else begin
      nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], bus.i_nmi_n};
      irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], bus.i_irq_n};
      nmi_prev_q <= nmi_sync_q[SYNC_STAGES-1];
    end
  end

  // State and sequence registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= S_RESET;
      nmi_latch_q <= 1'b0;
      kind_q      <= KIND_RESET;
      vector_q    <= RESET_VECTOR;
      b_flag_q    <= 1'b0;
      set_i_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      nmi_latch_q <= nmi_latch_d;
      kind_q      <= kind_d;
      vector_q    <= vector_d;
      b_flag_q    <= b_flag_d;
      set_i_q     <= set_i_d;
    end
  end

  // Next-state decode: arbitration, hijack and NMI latch update.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    vector_d  = vector_q;
    b_flag_d  = b_flag_q;
    set_i_d   = 1'b0;
    nmi_clear = 1'b0;

    case (state_q)
      S_RESET: begin
        if (bus.i_ack) begin
          state_d  = S_SERVICE;
          kind_d   = KIND_RESET;
          vector_d = RESET_VECTOR;
          b_flag_d = 1'b0;
        end
      end
      S_IDLE: begin
        if (bus.i_sync && nmi_latch_q) begin
          state_d  = S_PENDING;
          kind_d   = KIND_NMI;
          vector_d = NMI_VECTOR;
          b_flag_d = 1'b0;
        end else if (bus.i_sync && irq_active) begin
          state_d  = S_PENDING;
          kind_d   = KIND_IRQ;
          vector_d = IRQ_VECTOR;
          b_flag_d = 1'b0;
        end else if (bus.i_ack && bus.i_brk) begin
          state_d  = S_SERVICE;
          kind_d   = KIND_BRK;
          vector_d = IRQ_VECTOR;
          b_flag_d = 1'b1;
        end
      end
      S_PENDING: begin
        // The poll decision is final; IRQ or I changing here cannot cancel it.
        if (bus.i_ack) begin
          state_d  = S_SERVICE;
          b_flag_d = 1'b0;
        end
      end
      S_SERVICE: begin
        if (bus.i_vec_rd) begin
          state_d = S_IDLE;
          set_i_d = 1'b1;
          // A reset sequence never touches the NMI latch; NMI always consumes it,
          // IRQ/BRK consume it only when hijacked (latch already set).
          if (kind_q != KIND_RESET) begin
            nmi_clear = 1'b1;
          end
          if ((kind_q == KIND_IRQ || kind_q == KIND_BRK) && nmi_latch_q) begin
            kind_d   = KIND_NMI;
            vector_d = NMI_VECTOR;
          end
        end
      end
      default: state_d = S_RESET;
    endcase

    // A new edge wins over a clear in the same cycle so that NMI is not lost.
    nmi_latch_d = nmi_edge | (nmi_latch_q & ~nmi_clear);
  end

  assign bus.o_int_pending = (state_q == S_RESET) || (state_q == S_PENDING);
  assign bus.o_in_service  = (state_q == S_SERVICE);
  assign bus.o_kind        = kind_q;
  assign bus.o_vector      = vector_q;
  assign bus.o_b_flag      = b_flag_q;
  assign bus.o_set_i       = set_i_q;
  assign bus.o_nmi_latched = nmi_latch_q;

endmodule

// File: tb/tb_interrupt_control.sv
// Directed bench for interrupt_control: reset, NMI, IRQ, BRK, hijack,
// same-cycle edge/clear and reset during service.
module tb_interrupt_control;
  logic i_clk;
  logic i_reset_n;
  int   checks;
  int   errors;

  interrupt_control_if bus ();

  interrupt_control #(
    .SYNC_STAGES (2),
    .NMI_VECTOR  (16'hFFFA),
    .RESET_VECTOR(16'hFFFC),
    .IRQ_VECTOR  (16'hFFFE)
  ) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .bus      (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one rising edge and settle; inputs set afterwards apply to the next edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    i_reset_n    = 1'b0;
    bus.i_nmi_n  = 1'b1;
    bus.i_irq_n  = 1'b1;
    bus.i_p_i    = 1'b1;
    bus.i_sync   = 1'b0;
    bus.i_brk    = 1'b0;
    bus.i_ack    = 1'b0;
    bus.i_vec_rd = 1'b0;

    // Reset held three cycles
    tick(3);
    chk("rst_pending", 16'(bus.o_int_pending), 16'd1);
    chk("rst_in_service", 16'(bus.o_in_service), 16'd0);
    chk("rst_kind", 16'(bus.o_kind), 16'd0);
    chk("rst_vector", bus.o_vector, 16'hFFFC);
    chk("rst_set_i", 16'(bus.o_set_i), 16'd0);
    chk("rst_b_flag", 16'(bus.o_b_flag), 16'd0);
    chk("rst_latched", 16'(bus.o_nmi_latched), 16'd0);
    i_reset_n = 1'b1;
    tick(1);
    chk("post_rst_pending", 16'(bus.o_int_pending), 16'd1);

    // Reset sequence: ack then vector fetch
    bus.i_ack = 1'b1; bus.i_brk = 1'b1;
    tick(1);
    bus.i_ack = 1'b0; bus.i_brk = 1'b0;
    chk("rst_ack_in_service", 16'(bus.o_in_service), 16'd1);
    chk("rst_ack_kind", 16'(bus.o_kind), 16'd0);
    chk("rst_ack_b_flag", 16'(bus.o_b_flag), 16'd0);
    chk("rst_ack_pending", 16'(bus.o_int_pending), 16'd0);
    bus.i_vec_rd = 1'b1;
    tick(1);
    bus.i_vec_rd = 1'b0;
    chk("rst_vec_set_i", 16'(bus.o_set_i), 16'd1);
    chk("rst_vec_in_service", 16'(bus.o_in_service), 16'd0);
    chk("rst_vec_pending", 16'(bus.o_int_pending), 16'd0);
    chk("rst_vec_vector", bus.o_vector, 16'hFFFC);
    tick(1);
    chk("rst_set_i_one_cycle", 16'(bus.o_set_i), 16'd0);

    // NMI held low: latch after the third sampling edge
    bus.i_nmi_n = 1'b0;
    tick(2);
    chk("nmi_not_yet", 16'(bus.o_nmi_latched), 16'd0);
    tick(1);
    chk("nmi_latched", 16'(bus.o_nmi_latched), 16'd1);
    bus.i_sync = 1'b1;
    tick(1);
    bus.i_sync = 1'b0;
    chk("nmi_pending", 16'(bus.o_int_pending), 16'd1);
    chk("nmi_kind", 16'(bus.o_kind), 16'd1);
    chk("nmi_vector", bus.o_vector, 16'hFFFA);
    bus.i_ack = 1'b1;
    tick(1);
    bus.i_ack = 1'b0;
    chk("nmi_in_service", 16'(bus.o_in_service), 16'd1);
    chk("nmi_latch_kept_in_service", 16'(bus.o_nmi_latched), 16'd1);
    bus.i_vec_rd = 1'b1;
    tick(1);
    bus.i_vec_rd = 1'b0;
    chk("nmi_latch_cleared", 16'(bus.o_nmi_latched), 16'd0);
    chk("nmi_set_i", 16'(bus.o_set_i), 16'd1);
    bus.i_sync = 1'b1;
    tick(1);
    bus.i_sync = 1'b0;
    chk("nmi_held_no_second", 16'(bus.o_int_pending), 16'd0);
    chk("nmi_held_no_relatch", 16'(bus.o_nmi_latched), 16'd0);
    bus.i_nmi_n = 1'b1;
    tick(3);

    // IRQ masked, then unmasked, then released before ack
    bus.i_irq_n = 1'b0;
    tick(3);
    bus.i_sync = 1'b1;
    tick(1);
    bus.i_sync = 1'b0;
    chk("irq_masked", 16'(bus.o_int_pending), 16'd0);
    bus.i_p_i = 1'b0; bus.i_sync = 1'b1;
    tick(1);
    bus.i_sync = 1'b0;
    chk("irq_pending", 16'(bus.o_int_pending), 16'd1);
    chk("irq_kind", 16'(bus.o_kind), 16'd2);
    chk("irq_vector", bus.o_vector, 16'hFFFE);
    bus.i_irq_n = 1'b1; bus.i_p_i = 1'b1;
    tick(3);
    chk("irq_decision_kept", 16'(bus.o_int_pending), 16'd1);
    bus.i_ack = 1'b1;
    tick(1);
    bus.i_ack = 1'b0;
    chk("irq_in_service", 16'(bus.o_in_service), 16'd1);
    chk("irq_b_flag", 16'(bus.o_b_flag), 16'd0);
    chk("irq_kind_service", 16'(bus.o_kind), 16'd2);
    bus.i_vec_rd = 1'b1;
    tick(1);
    bus.i_vec_rd = 1'b0;
    chk("irq_set_i", 16'(bus.o_set_i), 16'd1);
    chk("irq_vector_commit", bus.o_vector, 16'hFFFE);

    // BRK hijacked by an NMI edge before the vector fetch
    bus.i_ack = 1'b1; bus.i_brk = 1'b1;
    tick(1);
    bus.i_ack = 1'b0; bus.i_brk = 1'b0;
    chk("brk_kind", 16'(bus.o_kind), 16'd3);
    chk("brk_b_flag", 16'(bus.o_b_flag), 16'd1);
    chk("brk_vector", bus.o_vector, 16'hFFFE);
    chk("brk_in_service", 16'(bus.o_in_service), 16'd1);
    bus.i_nmi_n = 1'b0;
    tick(3);
    chk("brk_nmi_latched", 16'(bus.o_nmi_latched), 16'd1);
    bus.i_vec_rd = 1'b1;
    tick(1);
    bus.i_vec_rd = 1'b0;
    chk("hijack_vector", bus.o_vector, 16'hFFFA);
    chk("hijack_kind", 16'(bus.o_kind), 16'd1);
    chk("hijack_b_flag", 16'(bus.o_b_flag), 16'd1);
    chk("hijack_latch_clear", 16'(bus.o_nmi_latched), 16'd0);
    chk("hijack_set_i", 16'(bus.o_set_i), 16'd1);
    bus.i_nmi_n = 1'b1;
    tick(3);

    // NMI beats IRQ at the poll point
    bus.i_irq_n = 1'b0; bus.i_p_i = 1'b0; bus.i_nmi_n = 1'b0;
    tick(3);
    bus.i_sync = 1'b1;
    tick(1);
    bus.i_sync = 1'b0;
    chk("prio_nmi_kind", 16'(bus.o_kind), 16'd1);
    bus.i_ack = 1'b1;
    tick(1);
    bus.i_ack = 1'b0;
    // New NMI edge lands on the same edge as the vector commit clear
    bus.i_nmi_n = 1'b1;
    tick(3);
    bus.i_nmi_n = 1'b0;
    tick(2);
    bus.i_vec_rd = 1'b1;
    tick(1);
    bus.i_vec_rd = 1'b0;
    chk("edge_vs_clear_latch", 16'(bus.o_nmi_latched), 16'd1);
    chk("edge_vs_clear_set_i", 16'(bus.o_set_i), 16'd1);
    bus.i_sync = 1'b1;
    tick(1);
    bus.i_sync = 1'b0;
    chk("relatched_nmi_pending", 16'(bus.o_int_pending), 16'd1);
    chk("relatched_nmi_kind", 16'(bus.o_kind), 16'd1);
    bus.i_ack = 1'b1;
    tick(1);
    bus.i_ack = 1'b0;
    bus.i_vec_rd = 1'b1;
    tick(1);
    bus.i_vec_rd = 1'b0;
    chk("relatched_nmi_clear", 16'(bus.o_nmi_latched), 16'd0);

    // IRQ still active: take it, then reset mid-service
    bus.i_sync = 1'b1;
    tick(1);
    bus.i_sync = 1'b0;
    chk("irq2_kind", 16'(bus.o_kind), 16'd2);
    bus.i_ack = 1'b1;
    tick(1);
    bus.i_ack = 1'b0;
    bus.i_nmi_n = 1'b1;
    tick(3);
    bus.i_nmi_n = 1'b0;
    tick(3);
    chk("irq2_nmi_latched", 16'(bus.o_nmi_latched), 16'd1);
    i_reset_n = 1'b0; bus.i_vec_rd = 1'b1;
    tick(1);
    bus.i_vec_rd = 1'b0;
    chk("abort_no_set_i", 16'(bus.o_set_i), 16'd0);
    chk("abort_in_service", 16'(bus.o_in_service), 16'd0);
    chk("abort_latched", 16'(bus.o_nmi_latched), 16'd0);
    i_reset_n = 1'b1;
    tick(1);
    chk("abort_vector", bus.o_vector, 16'hFFFC);
    chk("abort_kind", 16'(bus.o_kind), 16'd0);
    chk("abort_pending", 16'(bus.o_int_pending), 16'd1);
    chk("abort_set_i_after", 16'(bus.o_set_i), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
